pc_sequencer: RTL and testbench

//  Program-counter register and fetch sequencer for the simple CPU. Holds the current

---
 rtl/pc_sequencer_pkg.sv | 12 +
 rtl/pc_sequencer_if.sv | 11 +
 rtl/pc_next_sel.sv | 26 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings and default width for the PC sequencer
package pc_sequencer_pkg;

  localparam int AW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction fetch handshake between PC sequencer and memory
interface pc_sequencer_if #(
  parameter int AW = 4
);
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] pc;

  modport master (output mem_req, output pc, input mem_ack);
  modport slave  (input mem_req, input pc, output mem_ack);
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC selection at fetch completion: jump, pending jump, or increment
module pc_next_sel #(
  parameter int AW = 4
) (
  input  logic [AW-1:0] pc,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr,
  input  logic          pend,
  input  logic [AW-1:0] pend_addr,
  output logic [AW-1:0] next_pc,
  output logic          wrap_next
);

  // A same-cycle jump beats a pending one; wrap only counts on the increment path.
  always_comb begin
    if (jmp) begin
      next_pc = jmp_addr;
    end else if (pend) begin
      next_pc = pend_addr;
    end else begin
      next_pc = pc + AW'(1);
    end
    wrap_next = !jmp && !pend && (&pc);
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter register and req/ack fetch sequencer
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int            AW       = AW_DEFAULT,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   jmp,
  input  logic [AW-1:0]          jmp_addr,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic                   fetch_vld,
  output logic                   wrap,
  output logic                   halted,
  pc_sequencer_if.master         bus
);

  state_t        state, state_nx;
  logic [AW-1:0] pc_d, pend_addr, pend_addr_d, next_pc;
  logic          pend, pend_d, wrap_next, fetch_vld_d, wrap_d;

  pc_next_sel #(.AW(AW)) u_next_sel (
    .pc        (bus.pc),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .pend      (pend),
    .pend_addr (pend_addr),
    .next_pc   (next_pc),
    .wrap_next (wrap_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // halt_req and en are only looked at when a fetch completes, never mid-fetch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (en) state_nx = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ack) begin
          if (halt_req)  state_nx = ST_HALT;
          else if (!en)  state_nx = ST_IDLE;
          else           state_nx = ST_FETCH;
        end
      end
      ST_HALT: if (resume) state_nx = ST_FETCH;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d        = bus.pc;
    pend_d      = pend;
    pend_addr_d = pend_addr;
    fetch_vld_d = 1'b0;
    wrap_d      = 1'b0;
    case (state)
      ST_FETCH: begin
        if (bus.mem_ack) begin
          pc_d        = next_pc;
          pend_d      = 1'b0;
          fetch_vld_d = 1'b1;
          wrap_d      = wrap_next;
        end else if (jmp) begin
          pend_d      = 1'b1;
          pend_addr_d = jmp_addr;
        end
      end
      ST_IDLE, ST_HALT: if (jmp) pc_d = jmp_addr;
      default: ;
    endcase
  end

  // mem_req/halted decode the next state so they stay registered yet track the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pc      <= RESET_PC;
      bus.mem_req <= 1'b0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      fetch_vld   <= 1'b0;
      wrap        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      bus.pc      <= pc_d;
      bus.mem_req <= (state_nx == ST_FETCH);
      pend        <= pend_d;
      pend_addr   <= pend_addr_d;
      fetch_vld   <= fetch_vld_d;
      wrap        <= wrap_d;
      halted      <= (state_nx == ST_HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          jmp = 1'b0;
  logic [AW-1:0] jmp_addr = '0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          fetch_vld, wrap, halted;
  logic          ack_auto = 1'b0;
  logic          ack_man = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  pc_sequencer_if #(.AW(AW)) bus ();

  // 1-cycle memory: acks whatever is requested, or driven by hand for slow cases
  assign bus.mem_ack = ack_auto ? bus.mem_req : ack_man;

  pc_sequencer #(.AW(AW), .RESET_PC(4'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .halt_req  (halt_req),
    .resume    (resume),
    .fetch_vld (fetch_vld),
    .wrap      (wrap),
    .halted    (halted),
    .bus       (bus.master)
  );

  always #500 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset mid-fetch with a nonzero pc
    tick(); tick();
    rst = 1'b1;
    check_eq("rst_pc", 32'(bus.pc), 32'd0);
    check_eq("rst_req", 32'(bus.mem_req), 32'd0);
    jmp = 1'b1; jmp_addr = 4'd6;
    tick();
    jmp = 1'b0;
    check_eq("idle_jmp_pc", 32'(bus.pc), 32'd6);
    check_eq("idle_jmp_vld", 32'(fetch_vld), 32'd0);
    en = 1'b1;
    tick();
    check_eq("fetch_req", 32'(bus.mem_req), 32'd1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check_eq("pre_rst_pc", 32'(bus.pc), 32'd7);
    check_eq("pre_rst_vld", 32'(fetch_vld), 32'd1);
    #100 rst = 1'b0;
    #1;
    check_eq("async_rst_pc", 32'(bus.pc), 32'd0);
    check_eq("async_rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("async_rst_vld", 32'(fetch_vld), 32'd0);
    check_eq("async_rst_halt", 32'(halted), 32'd0);
    tick();
    rst = 1'b1;

    // free run with ack every cycle, wrap on 15 -> 0
    ack_auto = 1'b1;
    tick();
    check_eq("run_start_pc", 32'(bus.pc), 32'd0);
    check_eq("run_start_req", 32'(bus.mem_req), 32'd1);
    check_eq("run_start_vld", 32'(fetch_vld), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check_eq($sformatf("run_pc_%0d", i), 32'(bus.pc), 32'(i % 16));
      check_eq($sformatf("run_vld_%0d", i), 32'(fetch_vld), 32'd1);
      check_eq($sformatf("run_wrap_%0d", i), 32'(wrap), (i == 16) ? 32'd1 : 32'd0);
    end
    en = 1'b0;
    tick();
    ack_auto = 1'b0;
    check_eq("stop_pc", 32'(bus.pc), 32'd1);
    check_eq("stop_req", 32'(bus.mem_req), 32'd0);
    check_eq("stop_wrap", 32'(wrap), 32'd0);

    // slow memory: pc=5 held 3 cycles, one fetch_vld
    jmp = 1'b1; jmp_addr = 4'd5;
    tick();
    jmp = 1'b0; en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("slow_req_%0d", k), 32'(bus.mem_req), 32'd1);
      check_eq($sformatf("slow_pc_%0d", k), 32'(bus.pc), 32'd5);
      check_eq($sformatf("slow_vld_%0d", k), 32'(fetch_vld), 32'd0);
      if (k == 2) ack_man = 1'b1;
      tick();
    end
    ack_man = 1'b0;
    check_eq("slow_done_pc", 32'(bus.pc), 32'd6);
    check_eq("slow_done_vld", 32'(fetch_vld), 32'd1);
    tick();
    check_eq("slow_single_vld", 32'(fetch_vld), 32'd0);
    check_eq("slow_next_req", 32'(bus.mem_req), 32'd1);

    // pending jumps: later one overwrites, same-cycle jump beats pending
    jmp = 1'b1; jmp_addr = 4'd9;
    tick();
    jmp_addr = 4'd12;
    tick();
    jmp = 1'b0;
    check_eq("pend_hold_pc", 32'(bus.pc), 32'd6);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check_eq("pend_pc", 32'(bus.pc), 32'd12);
    check_eq("pend_wrap", 32'(wrap), 32'd0);
    jmp = 1'b1; jmp_addr = 4'd12;
    tick();
    jmp_addr = 4'd3; ack_man = 1'b1;
    tick();
    jmp = 1'b0;
    check_eq("jmp_on_ack_pc", 32'(bus.pc), 32'd3);
    tick();
    ack_man = 1'b0;
    check_eq("pend_cleared_pc", 32'(bus.pc), 32'd4);

    // halt after current fetch, ack in HALT ignored, resume with jump
    halt_req = 1'b1;
    tick();
    check_eq("halt_wait_req", 32'(bus.mem_req), 32'd1);
    check_eq("halt_wait_h", 32'(halted), 32'd0);
    ack_man = 1'b1;
    tick();
    check_eq("halt_pc", 32'(bus.pc), 32'd5);
    check_eq("halt_h", 32'(halted), 32'd1);
    check_eq("halt_req_low", 32'(bus.mem_req), 32'd0);
    check_eq("halt_vld", 32'(fetch_vld), 32'd1);
    tick();
    check_eq("halt_ack_ign_pc", 32'(bus.pc), 32'd5);
    check_eq("halt_ack_ign_vld", 32'(fetch_vld), 32'd0);
    ack_man = 1'b0; halt_req = 1'b0;
    resume = 1'b1; jmp = 1'b1; jmp_addr = 4'd2;
    tick();
    resume = 1'b0; jmp = 1'b0;
    check_eq("resume_pc", 32'(bus.pc), 32'd2);
    check_eq("resume_h", 32'(halted), 32'd0);
    check_eq("resume_req", 32'(bus.mem_req), 32'd1);

    // en drop mid-fetch: fetch completes then IDLE
    ack_man = 1'b1; jmp = 1'b1; jmp_addr = 4'd7;
    tick();
    ack_man = 1'b0; jmp = 1'b0; en = 1'b0;
    check_eq("endrop_start_pc", 32'(bus.pc), 32'd7);
    tick();
    check_eq("endrop_wait_req", 32'(bus.mem_req), 32'd1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check_eq("endrop_pc", 32'(bus.pc), 32'd8);
    check_eq("endrop_req", 32'(bus.mem_req), 32'd0);
    check_eq("endrop_vld", 32'(fetch_vld), 32'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check_eq("idle_resume_req", 32'(bus.mem_req), 32'd0);
    check_eq("idle_resume_pc", 32'(bus.pc), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
